// File: rtl/instr_mem_loader.sv
// Boot loader for the instruction memory: assembles a length-prefixed, XOR-checksummed
// byte stream into 32-bit words and holds the core in reset until a good image is loaded.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | post-reset, waiting for start, core held
// LEN_LO | waiting for word-count low byte
// LEN_HI | waiting for word-count high byte, length is judged here
// DATA   | collecting the four little-endian bytes of the next word
// WRITE  | one-cycle memory write of the assembled word
// CHECK  | waiting for the checksum byte
// DONE   | image verified, core released
// ERROR  | bad length or checksum, core held
module instr_mem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_in,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  core_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LEN_LO = 3'd1;
  localparam logic [2:0] LEN_HI = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] WRITE  = 3'd4;
  localparam logic [2:0] CHECK  = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;
  localparam logic [2:0] ERROR  = 3'd7;

  localparam logic [16:0] CAP = 17'(1) << ADDR_WIDTH;

  logic [2:0]  state;
  logic [15:0] len;
  logic [1:0]  byte_idx;
  logic [7:0]  csum;
  logic        armed;
  logic        xfer;
  logic        start_ok;
  logic [15:0] n_full;
  logic [15:0] next_count;

  assign byte_ready = (state == LEN_LO) || (state == LEN_HI) ||
                      (state == DATA)   || (state == CHECK);
  assign mem_we     = (state == WRITE);
  assign busy       = !((state == IDLE) || (state == DONE) || (state == ERROR));
  assign done       = (state == DONE);
  assign error      = (state == ERROR);
  assign core_hold  = (state != DONE);

  assign xfer       = byte_valid & byte_ready;
  // armed blocks a start that coincides with the first edge after reset release
  assign start_ok   = start & armed;
  assign n_full     = {byte_in, len[7:0]};
  assign next_count = 16'(word_count) + 16'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      len        <= '0;
      byte_idx   <= '0;
      csum       <= '0;
      armed      <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      word_count <= '0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE, DONE, ERROR: begin
          if (start_ok) begin
            state      <= LEN_LO;
            word_count <= '0;
            csum       <= '0;
            byte_idx   <= '0;
          end
        end
        LEN_LO: begin
          if (xfer) begin
            len[7:0] <= byte_in;
            state    <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (xfer) begin
            len[15:8] <= byte_in;
            if ({1'b0, n_full} > CAP)
              state <= ERROR;
            else if (n_full == 16'd0)
              state <= CHECK;
            else
              state <= DATA;
          end
        end
        DATA: begin
          if (xfer) begin
            csum                            <= csum ^ byte_in;
            mem_wdata[{byte_idx, 3'b000} +: 8] <= byte_in;
            byte_idx                        <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              state    <= WRITE;
              mem_addr <= word_count[ADDR_WIDTH-1:0];
            end
          end
        end
        WRITE: begin
          // word_count doubles as the write index; it reaches N only after the last write
          word_count <= word_count + {{ADDR_WIDTH{1'b0}}, 1'b1};
          state      <= (next_count == len) ? CHECK : DATA;
        end
        CHECK: begin
          if (xfer)
            state <= (byte_in == csum) ? DONE : ERROR;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
